// File: rtl/keyfile_pkg.sv
// Shared definitions for the keyfile checker: register offsets, CTRL/STATUS
// bit positions and the compare FSM encoding.
package keyfile_pkg;

  localparam logic [3:0] OFF_CAND0    = 4'h0;
  localparam logic [3:0] OFF_CAND1    = 4'h2;
  localparam logic [3:0] OFF_CAND2    = 4'h4;
  localparam logic [3:0] OFF_CAND3    = 4'h6;
  localparam logic [3:0] OFF_CTRL     = 4'h8;
  localparam logic [3:0] OFF_STATUS   = 4'hA;
  localparam logic [3:0] OFF_LOCK_CNT = 4'hC;

  localparam int CTRL_START    = 0;
  localparam int CTRL_CLR_CAND = 1;
  localparam int CTRL_RELOCK   = 2;

  localparam int ST_BUSY     = 0;
  localparam int ST_MATCH    = 1;
  localparam int ST_DONE     = 2;
  localparam int ST_LOCKED   = 3;
  localparam int ST_NOKEY    = 4;
  localparam int ST_FAIL_LSB = 8;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMP0 = 3'd1,
    S_CMP1 = 3'd2,
    S_CMP2 = 3'd3,
    S_CMP3 = 3'd4
  } state_e;

  // Slice 0 is the most significant word.
  function automatic logic [15:0] slice16(input logic [63:0] v, input logic [1:0] n);
    return 16'(v >> (7'd16 * (7'd3 - 7'(n))));
  endfunction

endpackage

// File: rtl/keyfile_lockout_timer.sv
// Consecutive-failure counter and SMCLK-timed lockout window.
module keyfile_lockout_timer #(
  parameter int          MAX_FAILS  = 3,
  parameter logic [15:0] LOCK_TICKS = 16'd1000
) (
  input  logic        mclk,
  input  logic        puc_rst_n,
  input  logic        fail_i,
  input  logic        pass_i,
  input  logic        smclk_en,
  output logic [3:0]  fail_cnt_o,
  output logic [15:0] lock_cnt_o,
  output logic        locked_o
);

  logic [3:0]  fail_cnt_q, fail_cnt_d;
  logic [15:0] lock_cnt_q, lock_cnt_d;
  logic        locked_q, locked_d;

  always_comb begin
    fail_cnt_d = fail_cnt_q;
    lock_cnt_d = lock_cnt_q;
    locked_d   = locked_q;
    if (locked_q && smclk_en) begin
      lock_cnt_d = lock_cnt_q - 16'd1;
      if (lock_cnt_q == 16'd1) begin
        locked_d   = 1'b0;
        fail_cnt_d = 4'd0;
      end
    end
    if (pass_i) begin
      fail_cnt_d = 4'd0;
    end else if (fail_i) begin
      if (fail_cnt_q + 4'd1 == 4'(MAX_FAILS)) begin
        locked_d   = 1'b1;
        lock_cnt_d = LOCK_TICKS;
        fail_cnt_d = 4'(MAX_FAILS);
      end else begin
        fail_cnt_d = fail_cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      fail_cnt_q <= 4'd0;
      lock_cnt_q <= 16'd0;
      locked_q   <= 1'b0;
    end else begin
      fail_cnt_q <= fail_cnt_d;
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
    end
  end

  assign fail_cnt_o = fail_cnt_q;
  assign lock_cnt_o = lock_cnt_q;
  assign locked_o   = locked_q;

endmodule

// File: rtl/keyfile_checker.sv
// Peripheral-bus key checker: fixed 4-cycle compare of a software candidate
// against a snapshot of the keyfile value, with unlock level and lockout.
module keyfile_checker
  import keyfile_pkg::*;
#(
  parameter logic [14:0] BASE_ADDR  = 15'h00B0,
  parameter int          DEC_WD     = 4,
  parameter int          MAX_FAILS  = 3,
  parameter logic [15:0] LOCK_TICKS = 16'd1000
) (
  input  logic        mclk,
  input  logic        puc_rst_n,
  input  logic [13:0] per_addr,
  input  logic [15:0] per_din,
  input  logic        per_en,
  input  logic [1:0]  per_we,
  input  logic        smclk_en,
  input  logic [63:0] key_data_in,
  output logic [15:0] per_dout,
  output logic        key_ok
);

  state_e      state_q, state_d;
  logic [63:0] cand_q, cand_d;
  logic [63:0] key_snap_q, key_snap_d;
  logic        match_q, match_d;
  logic        done_q, done_d;
  logic        nokey_q, nokey_d;
  logic        key_ok_q, key_ok_d;
  logic        mismatch_q, mismatch_d;

  logic        sel, wr_en, rd_en, ctrl_wr, busy;
  logic [3:0]  reg_off;
  logic [1:0]  cmp_idx;
  logic        fail_p, pass_p, locked;
  logic [3:0]  fail_cnt;
  logic [15:0] lock_cnt;

  assign sel     = per_en & (per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD]);
  assign reg_off = 4'({per_addr[DEC_WD-2:0], 1'b0});
  assign wr_en   = sel & (|per_we);
  assign rd_en   = sel & ~(|per_we);
  assign ctrl_wr = wr_en & (reg_off == OFF_CTRL);
  assign busy    = (state_q != S_IDLE);

  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    key_snap_d = key_snap_q;
    match_d    = match_q;
    done_d     = done_q;
    nokey_d    = nokey_q;
    key_ok_d   = key_ok_q;
    mismatch_d = mismatch_q;
    fail_p     = 1'b0;
    pass_p     = 1'b0;
    cmp_idx    = 2'd0;

    // RELOCK first so that a completing compare can still set the flags.
    if (ctrl_wr && per_din[CTRL_RELOCK]) begin
      key_ok_d = 1'b0;
      match_d  = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (wr_en) begin
          case (reg_off)
            OFF_CAND0: cand_d[63:48] = per_din;
            OFF_CAND1: cand_d[47:32] = per_din;
            OFF_CAND2: cand_d[31:16] = per_din;
            OFF_CAND3: cand_d[15:0]  = per_din;
            default: ;
          endcase
        end
        if (ctrl_wr && per_din[CTRL_CLR_CAND]) cand_d = 64'd0;
        if (ctrl_wr && per_din[CTRL_START] && !locked) begin
          key_snap_d = key_data_in;
          done_d     = 1'b0;
          match_d    = 1'b0;
          key_ok_d   = 1'b0;
          nokey_d    = 1'b0;
          mismatch_d = 1'b0;
          state_d    = S_CMP0;
        end
      end
      S_CMP0: begin cmp_idx = 2'd0; state_d = S_CMP1; end
      S_CMP1: begin cmp_idx = 2'd1; state_d = S_CMP2; end
      S_CMP2: begin cmp_idx = 2'd2; state_d = S_CMP3; end
      S_CMP3: begin cmp_idx = 2'd3; state_d = S_IDLE; end
      default: state_d = S_IDLE;
    endcase

    if (busy) begin
      mismatch_d = mismatch_q | (slice16(cand_q, cmp_idx) != slice16(key_snap_q, cmp_idx));
    end

    if (state_q == S_CMP3) begin
      done_d = 1'b1;
      cand_d = 64'd0;
      if (key_snap_q == 64'd0) begin
        nokey_d = 1'b1;
        match_d = 1'b0;
      end else if (!mismatch_d) begin
        match_d  = 1'b1;
        key_ok_d = 1'b1;
        pass_p   = 1'b1;
      end else begin
        match_d = 1'b0;
        fail_p  = 1'b1;
      end
    end
  end

  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      state_q    <= S_IDLE;
      cand_q     <= 64'd0;
      key_snap_q <= 64'd0;
      match_q    <= 1'b0;
      done_q     <= 1'b0;
      nokey_q    <= 1'b0;
      key_ok_q   <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cand_q     <= cand_d;
      key_snap_q <= key_snap_d;
      match_q    <= match_d;
      done_q     <= done_d;
      nokey_q    <= nokey_d;
      key_ok_q   <= key_ok_d;
      mismatch_q <= mismatch_d;
    end
  end

  keyfile_lockout_timer #(
    .MAX_FAILS (MAX_FAILS),
    .LOCK_TICKS(LOCK_TICKS)
  ) u_lockout (
    .mclk      (mclk),
    .puc_rst_n (puc_rst_n),
    .fail_i    (fail_p),
    .pass_i    (pass_p),
    .smclk_en  (smclk_en),
    .fail_cnt_o(fail_cnt),
    .lock_cnt_o(lock_cnt),
    .locked_o  (locked)
  );

  always_comb begin
    per_dout = 16'd0;
    if (rd_en) begin
      case (reg_off)
        OFF_STATUS: begin
          per_dout[ST_BUSY]                   = busy;
          per_dout[ST_MATCH]                  = match_q;
          per_dout[ST_DONE]                   = done_q;
          per_dout[ST_LOCKED]                 = locked;
          per_dout[ST_NOKEY]                  = nokey_q;
          per_dout[ST_FAIL_LSB+3:ST_FAIL_LSB] = fail_cnt;
        end
        OFF_LOCK_CNT: per_dout = lock_cnt;
        default: per_dout = 16'd0;
      endcase
    end
  end

  assign key_ok = key_ok_q;

endmodule

// File: tb/tb_keyfile_checker.sv
// Directed plus randomized bench for keyfile_checker against a whole-word
// behavioural model of the compare, failure count and lockout.
module tb_keyfile_checker;

  localparam logic [13:0] BASE_W    = 14'h0058;
  localparam int          MAXF      = 3;
  localparam int          LTICKS    = 1000;

  logic        mclk = 1'b0;
  logic        puc_rst_n;
  logic [13:0] per_addr;
  logic [15:0] per_din;
  logic        per_en;
  logic [1:0]  per_we;
  logic        smclk_en;
  logic [63:0] key_data_in;
  logic [15:0] per_dout;
  logic        key_ok;

  keyfile_checker dut (
    .mclk       (mclk),
    .puc_rst_n  (puc_rst_n),
    .per_addr   (per_addr),
    .per_din    (per_din),
    .per_en     (per_en),
    .per_we     (per_we),
    .smclk_en   (smclk_en),
    .key_data_in(key_data_in),
    .per_dout   (per_dout),
    .key_ok     (key_ok)
  );

  always #5 mclk = ~mclk;

  int errors = 0;
  int checks = 0;

  logic [63:0] m_cand, m_snap;
  bit          m_ko, m_match, m_done, m_nokey, m_locked;
  int          m_fail, m_lock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_status(input bit busy);
    return {4'b0, 4'(m_fail), 3'b0, m_nokey, m_locked, m_done, m_match, busy};
  endfunction

  task automatic model_reset();
    m_cand = 0; m_snap = 0; m_ko = 0; m_match = 0; m_done = 0;
    m_nokey = 0; m_locked = 0; m_fail = 0; m_lock = 0;
  endtask

  // Each bus task starts at a falling edge and ends at the next one.
  task automatic wr(input logic [3:0] off, input logic [15:0] d);
    per_addr = BASE_W + 14'(off[3:1]);
    per_din  = d;
    per_en   = 1'b1;
    per_we   = 2'b11;
    #1 chk("dout_on_write", per_dout, 0);
    @(negedge mclk);
    per_en = 1'b0;
    per_we = 2'b00;
  endtask

  task automatic rd(input logic [3:0] off, input logic [15:0] exp, input string tag);
    per_addr = BASE_W + 14'(off[3:1]);
    per_en   = 1'b1;
    per_we   = 2'b00;
    #1 chk(tag, per_dout, exp);
    chk({tag, "_key_ok"}, key_ok, m_ko);
    per_en = 1'b0;
    @(negedge mclk);
  endtask

  task automatic set_cand(input logic [63:0] c);
    wr(4'h0, c[63:48]);
    wr(4'h2, c[47:32]);
    wr(4'h4, c[31:16]);
    wr(4'h6, c[15:0]);
    m_cand = c;
  endtask

  task automatic model_start();
    m_snap = key_data_in; m_done = 0; m_match = 0; m_ko = 0; m_nokey = 0;
  endtask

  task automatic model_finish();
    m_done = 1;
    if (m_snap == 0) begin
      m_nokey = 1; m_match = 0;
    end else if (m_cand == m_snap) begin
      m_match = 1; m_ko = 1; m_fail = 0;
    end else begin
      m_match = 0;
      if (m_fail + 1 == MAXF) begin
        m_locked = 1; m_lock = LTICKS; m_fail = MAXF;
      end else m_fail++;
    end
    m_cand = 0;
  endtask

  // CTRL write from IDLE; when a compare starts, watch BUSY for all 4 cycles.
  task automatic ctrl(input logic [2:0] bits);
    bit started;
    started = bits[0] && !m_locked;
    wr(4'h8, {13'b0, bits});
    if (bits[2]) begin m_ko = 0; m_match = 0; end
    if (bits[1]) m_cand = 0;
    if (started) begin
      model_start();
      repeat (4) rd(4'hA, exp_status(1), "busy");
      model_finish();
    end
  endtask

  task automatic smclk(input int n);
    smclk_en = 1'b1;
    repeat (n) begin
      @(negedge mclk);
      if (m_locked) begin
        m_lock--;
        if (m_lock == 0) begin m_locked = 0; m_fail = 0; end
      end
    end
    smclk_en = 1'b0;
  endtask

  logic [63:0] k1, r64;

  initial begin
    puc_rst_n = 1'b0; per_addr = 0; per_din = 0; per_en = 0; per_we = 0;
    smclk_en = 0; key_data_in = 0;
    model_reset();

    // Reset state
    per_addr = BASE_W + 14'd5; per_en = 1'b1;
    #12 chk("rst_status", per_dout, 0);
    chk("rst_key_ok", key_ok, 0);
    per_en = 1'b0;
    @(negedge mclk); puc_rst_n = 1'b1; @(negedge mclk);
    rd(4'hA, 16'h0000, "status_idle");
    rd(4'hC, 16'h0000, "lock_cnt_idle");
    rd(4'hE, 16'h0000, "reserved");
    per_addr = 14'h0040; per_en = 1'b1; per_we = 0;
    #1 chk("unselected", per_dout, 0);
    per_en = 1'b0; @(negedge mclk);

    // Matching candidate
    k1 = 64'h0123_4567_89AB_CDEF;
    key_data_in = k1;
    set_cand(k1);
    ctrl(3'b001);
    rd(4'hA, 16'h0006, "match_status");
    rd(4'h0, 16'h0000, "cand0_read");

    // Three failures -> lockout
    for (int i = 0; i < 3; i++) begin
      set_cand(64'h0123_4567_89AB_CDEE);
      ctrl(3'b001);
      rd(4'hA, exp_status(0), "fail_status");
    end
    rd(4'hA, 16'h030C, "locked_status");
    rd(4'hC, 16'd1000, "lock_cnt_full");
    ctrl(3'b001);
    rd(4'hA, 16'h030C, "start_ignored");

    // Drain the lockout
    smclk(999);
    rd(4'hC, 16'd1, "lock_cnt_one");
    smclk(1);
    rd(4'hC, 16'd0, "lock_cnt_zero");
    rd(4'hA, 16'h0004, "unlocked_status");
    set_cand(k1);
    ctrl(3'b001);
    rd(4'hA, 16'h0006, "match_after_lock");

    // NOKEY leaves fail_cnt alone
    set_cand(64'h1);
    ctrl(3'b001);
    key_data_in = 64'd0;
    set_cand(64'hDEAD_BEEF_0000_0001);
    ctrl(3'b001);
    rd(4'hA, 16'h0114, "nokey_status");

    // Snapshot and busy-write immunity
    key_data_in = k1;
    set_cand(k1);
    wr(4'h8, 16'h0001);
    model_start();
    rd(4'hA, exp_status(1), "snap_busy0");
    key_data_in = '1;
    wr(4'h6, 16'h1234);
    rd(4'hA, exp_status(1), "snap_busy2");
    rd(4'hA, exp_status(1), "snap_busy3");
    model_finish();
    rd(4'hA, 16'h0006, "snap_match");

    // Reset during CMP2
    key_data_in = k1;
    set_cand(k1);
    wr(4'h8, 16'h0001);
    model_start();
    rd(4'hA, exp_status(1), "pre_rst0");
    rd(4'hA, exp_status(1), "pre_rst1");
    puc_rst_n = 1'b0;
    model_reset();
    per_addr = BASE_W + 14'd5; per_en = 1'b1;
    #1 chk("midrst_status", per_dout, 0);
    chk("midrst_key_ok", key_ok, 0);
    per_en = 1'b0;
    @(negedge mclk); puc_rst_n = 1'b1; @(negedge mclk);
    rd(4'hA, 16'h0000, "post_rst_status");
    ctrl(3'b001);
    rd(4'hA, 16'h0104, "post_rst_zero_cand");

    // RELOCK after a match, then CLR_CAND+START compares zero
    set_cand(k1);
    ctrl(3'b001);
    rd(4'hA, 16'h0006, "pre_relock");
    ctrl(3'b100);
    rd(4'hA, 16'h0004, "relock_status");
    set_cand(k1);
    ctrl(3'b011);
    rd(4'hA, 16'h0104, "clr_start");

    // Randomized compares
    for (int it = 0; it < 30; it++) begin
      r64 = {$urandom, $urandom};
      key_data_in = ($urandom_range(0, 7) == 0) ? 64'd0 : r64;
      case ($urandom_range(0, 2))
        0: set_cand(key_data_in);
        1: set_cand(key_data_in ^ (64'd1 << $urandom_range(0, 63)));
        default: set_cand({$urandom, $urandom});
      endcase
      ctrl(3'(1 | ($urandom_range(0, 3) << 1)));
      rd(4'hA, exp_status(0), "rand_status");
      rd(4'hC, 16'(m_lock), "rand_lock_cnt");
      if (m_locked && $urandom_range(0, 1) == 1) begin
        smclk(m_lock);
        rd(4'hA, exp_status(0), "rand_unlock");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/keyfile_checker.md
Name: keyfile_checker

Overview:
- Application-processor peripheral on the openMSP430 peripheral bus, directly downstream of the radio-side keyfile writer.
- Consumes the 64-bit key produced by the writer.
- Lets software submit a 64-bit candidate and runs a fixed-latency, non-early-exit compare against a snapshot of the key.
- Drives a `key_ok` unlock level and enforces a failed-attempt lockout timed on SMCLK.

Parameters:
- BASE_ADDR, 15'h00B0, peripheral base byte address (aligned to 2^DEC_WD).
- DEC_WD, 4, address decode width (8 word registers).
- MAX_FAILS, 3, consecutive failures that trigger lockout (1..15).
- LOCK_TICKS, 16'd1000, lockout duration in smclk_en pulses (must be nonzero).

Ports:
- mclk  in  1  main system clock
- puc_rst_n  in  1  reset, asynchronous, active-low
- per_addr  in  14  peripheral word address
- per_din  in  16  peripheral write data
- per_en  in  1  peripheral enable
- per_we  in  2  byte write enables; any nonzero value is a full-word write
- smclk_en  in  1  SMCLK enable pulse, lockout timebase
- key_data_in  in  64  keyfile value from the keyfile writer
- per_dout  out  16  read data; 0 when not selected
- key_ok  out  1  high after a successful compare

Behaviour:
- Register selection is `per_en & (per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD])`. Offsets are byte offsets.
- Register map:
  - 0x0 CAND0 = cand[63:48]; 0x2 CAND1 = cand[47:32]; 0x4 CAND2 = cand[31:16]; 0x6 CAND3 = cand[15:0]. Write-only; reads return 0.
  - 0x8 CTRL, write-only: bit0 START, bit1 CLR_CAND, bit2 RELOCK. Reads return 0.
  - 0xA STATUS, read-only: [0] BUSY, [1] MATCH, [2] DONE, [3] LOCKED, [4] NOKEY, [11:8] fail_cnt, all other bits 0.
  - 0xC LOCK_CNT, read-only: remaining lockout ticks.
  - 0xE: reserved, reads 0.
- Reset (puc_rst_n low): cand=0, key_snap=0, FSM=IDLE, all STATUS bits 0, fail_cnt=0, lock_cnt=0, key_ok=0, per_dout=0.
- FSM states: IDLE, CMP0, CMP1, CMP2, CMP3.
- IDLE:
  - START write accepted only when !LOCKED. On acceptance, at the same edge: key_snap <= key_data_in, DONE <= 0, MATCH <= 0, key_ok <= 0, NOKEY <= 0, mismatch <= 0, go to CMP0.
  - START while LOCKED is ignored; no flags change.
- CMPn (n=0..3): `mismatch |= (cand slice n != key_snap slice n)`, slice 0 = [63:48]. Always 4 cycles, never exits early.
- Exit from CMP3, at the same edge as the final accumulate, go to IDLE and:
  - DONE <= 1; cand <= 0 (a candidate is never reusable).
  - If key_snap == 0: NOKEY <= 1, MATCH <= 0, fail_cnt unchanged.
  - Else if no mismatch: MATCH <= 1, key_ok <= 1, fail_cnt <= 0.
  - Else: MATCH <= 0. If fail_cnt+1 == MAX_FAILS: LOCKED <= 1, lock_cnt <= LOCK_TICKS, fail_cnt <= MAX_FAILS. Otherwise fail_cnt increments.
- Latency: START write at edge E0; BUSY is visible after E0; DONE/MATCH/key_ok are visible after E4.
- BUSY is high in CMP0..CMP3.
- While BUSY, the following are ignored: CAND writes, START, CLR_CAND. RELOCK is honoured.
- CLR_CAND (in IDLE): cand <= 0.
- RELOCK (any state): key_ok <= 0, MATCH <= 0. The FSM is not aborted, and a compare in flight can still set them on completion.
- Lockout:
  - While LOCKED, lock_cnt decrements on each smclk_en.
  - At the edge where lock_cnt goes 1 -> 0: LOCKED <= 0, fail_cnt <= 0.
- Simultaneous events:
  - Writes to CTRL bits in the same word are processed in priority RELOCK, CLR_CAND, START. CLR_CAND with START clears cand first, so a zero candidate is compared.
- key_data_in changing mid-compare has no effect (snapshot).
- Reset mid-compare returns to IDLE with all state cleared.
- Reads are combinational from current state; per_dout is 0 when not selected or when written.

Decomposition:
- Shared package holds:
  - register offsets (CAND0..CAND3, CTRL, STATUS, LOCK_CNT);
  - CTRL and STATUS bit positions;
  - the FSM state encoding.
- One natural sub-module: `keyfile_lockout_timer`. It contains fail_cnt, lock_cnt, LOCKED and the smclk_en decrement. Its inputs are a fail pulse, a pass pulse and smclk_en.

Test Plan:
- key_data_in=64'h0123_4567_89AB_CDEF; write CAND0..3 = 0123/4567/89AB/CDEF; START -> BUSY for 4 cycles; then STATUS=16'h0006, key_ok=1, per_dout 0 on a CAND0 read.
- Same key, candidate with CAND3=CDEE, repeated 3 times with MAX_FAILS=3 -> fail_cnt 1, 2, then STATUS LOCKED=1, fail_cnt=3, LOCK_CNT=1000; a 4th START is ignored (DONE stays 1, BUSY stays 0).
- While locked, pulse smclk_en 1000 times -> LOCK_CNT reaches 0, LOCKED=0, fail_cnt=0; a correct candidate then gives MATCH=1.
- key_data_in=0, START with any candidate -> NOKEY=1, MATCH=0, fail_cnt unchanged.
- START, then change key_data_in to 64'hFFFF... during CMP1 -> result still compares against the original key and matches; a CAND write during BUSY does not alter the candidate.
- Assert puc_rst_n low during CMP2 -> all outputs 0, FSM in IDLE; RELOCK after a match -> key_ok=0, MATCH=0.
